ccr_unit: RTL and testbench
===========================

CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of freeze-stack entries for nested interrupts.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flagsIn  input  4  ALU flag outputs {NF,OF,CF,ZF}, bit 3 = NF, bit 0 = ZF.
REQ-005 SHALL have port flagsWrite  input  1  load flagsIn into the CCR.
REQ-006 SHALL have port stall  input  1  pipeline stall; blocks every state update.
REQ-007 SHALL have port intSave  input  1  interrupt entry; push the current CCR.
REQ-008 SHALL have port rtiRestore  input  1  RTI; pop the top entry.
REQ-009 SHALL have port branchType  input  2  00 JMP, 01 JZ, 10 JN, 11 JC.
REQ-010 SHALL have port branchValid  input  1  a branch is under evaluation this cycle.
REQ-011 SHALL have port ccr  output  4  current CCR {NF,OF,CF,ZF}, drives the ALU flag inputs.
REQ-012 SHALL have port freezedCCR  output  4  top freeze-stack entry, drives the ALU freezedCCR input.
REQ-013 SHALL have port branchTaken  output  1  branch resolution result.
REQ-014 SHALL have ports stackFull  output  1 and stackEmpty  output  1, reporting freeze-stack occupancy.
REQ-015 SHALL have port stackError  output  1  sticky flag for overflow or underflow.

Function
REQ-016 SHALL load ccr from flagsIn on a clock edge where flagsWrite=1 and stall=0; otherwise ccr SHALL hold.
REQ-017 SHALL push the pre-edge ccr value on an edge where intSave=1, stall=0 and the stack is not full, even when flagsWrite=1 in the same cycle.
REQ-018 SHALL decrement the stack pointer on an edge where rtiRestore=1, intSave=0, stall=0 and the stack is not empty.
REQ-019 SHALL present freezedCCR combinationally as the top entry when the stack is non-empty, and 4'b0000 when it is empty.
REQ-020 SHALL, when intSave and rtiRestore are both 1, perform the push only and ignore the restore.
REQ-021 SHALL, on a push while full, drop the push, leave the pointer and entries unchanged, and set stackError.
REQ-022 SHALL, on a pop while empty, leave the pointer unchanged and set stackError.
REQ-023 SHALL clear stackError only by reset.
REQ-024 SHALL ignore flagsWrite, intSave and rtiRestore while stall=1; every output SHALL hold.
REQ-025 SHALL drive branchTaken combinationally from the registered ccr, with no bypass from flagsIn:
- branchTaken = 0 when branchValid=0;
- JMP gives 1;
- JZ gives ccr[0];
- JN gives ccr[3];
- JC gives ccr[1].
REQ-026 SHALL drive stackEmpty=1 when occupancy is 0 and stackFull=1 when occupancy is DEPTH; occupancy SHALL range 0..DEPTH with no wrap-around.
REQ-027 SHALL have zero-cycle latency from an RTI pop to the ALU: the top entry SHALL remain visible on freezedCCR during the RTI cycle and SHALL be popped at that cycle's edge.

Reset
REQ-028 SHALL, while rst=0 and regardless of clk, force ccr=0000, stack pointer=0, stackEmpty=1, stackFull=0, stackError=0 and freezedCCR=0000.
REQ-029 SHALL not require the stack entry contents to be cleared by reset; freezedCCR SHALL still read 0 while the stack is empty.
REQ-030 SHALL, when reset is asserted mid-operation (for example during a push edge), complete no update, and SHALL leave the state at reset values on the first edge after deassertion.

Verification
REQ-031 SHALL cover flag load then branch: flagsIn=0001 with flagsWrite=1 -> next cycle ccr=0001; branchType=01 with branchValid=1 -> branchTaken=1; branchType=11 -> branchTaken=0.
REQ-032 SHALL cover nested save and restore: ccr=1000 and intSave; then ccr=0010 and intSave -> freezedCCR=0010; rtiRestore -> freezedCCR=1000; second rtiRestore -> stackEmpty=1 and freezedCCR=0000.
REQ-033 SHALL cover overflow: 5 pushes with DEPTH=4 -> stackFull=1, stackError=1, and the top entry still equals the 4th push.
REQ-034 SHALL cover underflow and simultaneous requests: rtiRestore when empty -> stackError=1; intSave and rtiRestore together with occupancy 1 -> occupancy 2.
REQ-035 SHALL cover stall: stall=1 with flagsWrite=1, flagsIn=1111 and intSave=1 -> ccr and occupancy unchanged.
REQ-036 SHALL cover asynchronous reset: drop rst between edges with occupancy 3 and ccr=0110 -> all outputs reach reset values immediately, before the next edge.

Source files
------------

// File: rtl/ccr_unit.sv
// Condition-code register with a freeze stack for nested interrupts
// and combinational branch resolution from the registered flags.
module ccr_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flagsIn,
  input  logic       flagsWrite,
  input  logic       stall,
  input  logic       intSave,
  input  logic       rtiRestore,
  input  logic [1:0] branchType,
  input  logic       branchValid,
  output logic [3:0] ccr,
  output logic [3:0] freezedCCR,
  output logic       branchTaken,
  output logic       stackFull,
  output logic       stackEmpty,
  output logic       stackError
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [3:0]     ccr_q, ccr_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [3:0]     mem_q [DEPTH];
  logic           full, empty;
  logic           push, pop;
  logic           push_ovf, pop_unf;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  // Save wins over restore when both arrive together.
  assign push     = intSave & ~stall & ~full;
  assign pop      = rtiRestore & ~intSave & ~stall & ~empty;
  assign push_ovf = intSave & ~stall & full;
  assign pop_unf  = rtiRestore & ~intSave & ~stall & empty;

  // Next-state for flags, stack pointer and sticky error.
  always_comb begin
    ccr_d = ccr_q;
    sp_d  = sp_q;
    err_d = err_q | push_ovf | pop_unf;
    if (flagsWrite && !stall) ccr_d = flagsIn;
    if (push)     sp_d = sp_q + SPW'(1);
    else if (pop) sp_d = sp_q - SPW'(1);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccr_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ccr_q <= ccr_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack entries; contents are unobservable until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SPW'(i)) mem_q[i] <= ccr_q;
      end
    end
  end

  // Top-of-stack view, zero when empty.
  always_comb begin
    freezedCCR = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) freezedCCR = mem_q[i];
    end
  end

  // Branch resolution from registered flags only.
  always_comb begin
    branchTaken = 1'b0;
    if (branchValid) begin
      unique case (branchType)
        2'b00:   branchTaken = 1'b1;
        2'b01:   branchTaken = ccr_q[0];
        2'b10:   branchTaken = ccr_q[3];
        default: branchTaken = ccr_q[1];
      endcase
    end
  end

  assign ccr        = ccr_q;
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign stackError = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_ccr_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flagsIn;
  logic       flagsWrite, stall, intSave, rtiRestore;
  logic [1:0] branchType;
  logic       branchValid;
  logic [3:0] ccr, freezedCCR;
  logic       branchTaken, stackFull, stackEmpty, stackError;

  ccr_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .flagsIn(flagsIn), .flagsWrite(flagsWrite),
    .stall(stall), .intSave(intSave),
    .rtiRestore(rtiRestore),
    .branchType(branchType), .branchValid(branchValid),
    .ccr(ccr), .freezedCCR(freezedCCR),
    .branchTaken(branchTaken),
    .stackFull(stackFull), .stackEmpty(stackEmpty),
    .stackError(stackError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ccr;
    logic [3:0] fz;
    logic       bt;
    logic       full;
    logic       empty;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  logic [3:0] m_ccr;
  logic [3:0] m_stk[$];
  logic       m_err;

  task automatic chk(string name, logic [3:0] act, logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  function automatic exp_t model_out(string tag, logic [1:0] bty, logic bv);
    exp_t e;
    e.ccr   = m_ccr;
    e.fz    = (m_stk.size() > 0) ? m_stk[$] : 4'b0000;
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    e.tag   = tag;
    if (!bv)             e.bt = 1'b0;
    else if (bty == 2'd0) e.bt = 1'b1;
    else if (bty == 2'd1) e.bt = m_ccr[0];
    else if (bty == 2'd2) e.bt = m_ccr[3];
    else                  e.bt = m_ccr[1];
    return e;
  endfunction

  // Drive one cycle at a negedge; the model predicts the post-edge view.
  task automatic step(string tag, logic fw, logic [3:0] fin, logic st,
                      logic is, logic rr, logic [1:0] bty, logic bv);
    logic [3:0] old;
    flagsWrite = fw; flagsIn = fin; stall = st;
    intSave = is; rtiRestore = rr;
    branchType = bty; branchValid = bv;
    if (!st) begin
      old = m_ccr;
      if (fw) m_ccr = fin;
      if (is) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(old);
        else m_err = 1'b1;
      end else if (rr) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1'b1;
      end
    end
    sb.push_back(model_out(tag, bty, bv));
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ccr = 4'b0000;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic chk_reset_now(string tag);
    chk({tag, ".ccr"},   ccr, 4'b0000);
    chk({tag, ".fz"},    freezedCCR, 4'b0000);
    chk({tag, ".empty"}, {3'b0, stackEmpty}, 4'd1);
    chk({tag, ".full"},  {3'b0, stackFull}, 4'd0);
    chk({tag, ".err"},   {3'b0, stackError}, 4'd0);
  endtask

  // Async reset between edges, held across a push edge, then released.
  task automatic async_reset(string tag);
    flagsWrite = 1'b1; flagsIn = 4'b1111;
    intSave = 1'b1; rtiRestore = 1'b0; stall = 1'b0;
    branchValid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_now(tag);
    model_reset();
    sb.push_back(model_out({tag, ".held"}, 2'd0, 1'b0));
    @(negedge clk);
    #1 rst = 1'b1;
    step({tag, ".post"}, 0, 4'h0, 0, 0, 0, 2'd0, 0);
  endtask

  // Monitor: compare DUT outputs after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".ccr"},   ccr, e.ccr);
        chk({e.tag, ".fz"},    freezedCCR, e.fz);
        chk({e.tag, ".bt"},    {3'b0, branchTaken}, {3'b0, e.bt});
        chk({e.tag, ".full"},  {3'b0, stackFull}, {3'b0, e.full});
        chk({e.tag, ".empty"}, {3'b0, stackEmpty}, {3'b0, e.empty});
        chk({e.tag, ".err"},   {3'b0, stackError}, {3'b0, e.err});
      end
    end
  end

  initial begin
    rst = 1'b0;
    flagsIn = '0; flagsWrite = 0; stall = 0;
    intSave = 0; rtiRestore = 0;
    branchType = '0; branchValid = 0;
    model_reset();
    #3 chk_reset_now("por");
    @(negedge clk);
    rst = 1'b1;

    // flag load then branch
    step("ld",  1, 4'b0001, 0, 0, 0, 2'b01, 1);
    step("jc",  0, 4'b0000, 0, 0, 0, 2'b11, 1);
    // registered flags only: flagsIn change is not seen before the edge
    flagsIn = 4'b1111; flagsWrite = 1'b1;
    branchType = 2'b11; branchValid = 1'b1;
    #1 chk("nobypass", {3'b0, branchTaken}, 4'd0);
    step("ldN", 1, 4'b1111, 0, 0, 0, 2'b10, 1);
    step("jmp", 0, 4'b0000, 0, 0, 0, 2'b00, 1);
    step("bv0", 0, 4'b0000, 0, 0, 0, 2'b00, 0);

    // nested save and restore
    step("n0", 1, 4'b1000, 0, 0, 0, 2'b00, 0);
    step("n1", 1, 4'b0010, 0, 1, 0, 2'b00, 0);
    step("n2", 0, 4'b0000, 0, 1, 0, 2'b00, 0);
    // RTI cycle: top still visible before the edge
    rtiRestore = 1'b1;
    #1 chk("rti.vis", freezedCCR, 4'b0010);
    step("r1", 0, 4'b0000, 0, 0, 1, 2'b00, 0);
    step("r2", 0, 4'b0000, 0, 0, 1, 2'b00, 0);

    // overflow with 5 pushes
    for (int i = 0; i < 5; i++)
      step("ovf", 1, 4'(i + 3), 0, 1, 0, 2'b00, 0);
    // stall blocks everything
    step("stl", 1, 4'b1111, 1, 1, 0, 2'b01, 1);
    step("stl2", 0, 4'b0000, 1, 0, 1, 2'b00, 0);

    async_reset("ar0");

    // underflow and simultaneous requests
    step("unf",  0, 4'b0000, 0, 0, 1, 2'b00, 0);
    step("p1",   1, 4'b0101, 0, 1, 0, 2'b00, 0);
    step("both", 0, 4'b0000, 0, 1, 1, 2'b00, 0);

    // async reset with occupancy 3 and ccr=0110
    step("p3",  1, 4'b0110, 0, 1, 0, 2'b00, 0);
    async_reset("ar1");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom), 4'($urandom), ($urandom % 5) == 0,
           ($urandom % 3) == 0, ($urandom % 3) == 0,
           2'($urandom), 1'($urandom));
      if (i == 200) async_reset("ar2");
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb.drain", 4'(sb.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
